// File: rtl/mips_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package mips_pkg;

    localparam int IW_DEFAULT = 32;

    localparam logic [IW_DEFAULT-1:0] NOP = '0;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a program survives a clr.
module instr_mem
    import mips_pkg::*;
#(
    parameter int W  = 6,
    parameter int IW = IW_DEFAULT
) (
    input  logic          clk,
    input  logic          we,
    input  logic [W-1:0]  waddr,
    input  logic [IW-1:0] wdata,
    input  logic [W-1:0]  raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [2**W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program-load / run FSM feeding the IF/ID register.
//   state | meaning
//   LOAD  | program is being written into instr_mem, no fetch, run=0
//   RUN   | memory read-only, IF/ID captures mem[pc] every unstalled edge
module instr_fetch
    import mips_pkg::*;
#(
    parameter int W  = 6,
    parameter int IW = IW_DEFAULT
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [W-1:0]  pc,
    input  logic          stall,
    input  logic          flush,
    input  logic          ld_en,
    input  logic [W-1:0]  ld_addr,
    input  logic [IW-1:0] ld_data,
    input  logic          ld_done,
    output logic          run,
    output logic [IW-1:0] ifid_instr,
    output logic [W-1:0]  ifid_pc,
    output logic [W-1:0]  ifid_pc1,
    output logic          ifid_valid
);

    state_t        state;
    logic          mem_we;
    logic [IW-1:0] mem_rdata;

    // Writes are only honoured in LOAD, and clr blocks a write in the same cycle.
    assign mem_we = (state == LOAD) && ld_en && !clr;

    instr_mem #(
        .W  (W),
        .IW (IW)
    ) u_instr_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= LOAD;
            run        <= 1'b0;
            ifid_instr <= IW'(NOP);
            ifid_pc    <= '0;
            ifid_pc1   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    // The transition edge itself does not fetch.
                    if (ld_done) begin
                        state <= RUN;
                        run   <= 1'b1;
                    end
                end
                RUN: begin
                    if (flush) begin
                        ifid_instr <= IW'(NOP);
                        ifid_pc    <= '0;
                        ifid_pc1   <= '0;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr <= mem_rdata;
                        ifid_pc    <= pc;
                        ifid_pc1   <= pc + W'(1);
                        ifid_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand sequences,
// then random stimulus against a behavioural model.
module tb_instr_fetch;

    localparam int W  = 6;
    localparam int IW = 32;
    localparam int DEPTH = 2**W;

    logic          clk;
    logic          clr;
    logic [W-1:0]  pc;
    logic          stall;
    logic          flush;
    logic          ld_en;
    logic [W-1:0]  ld_addr;
    logic [IW-1:0] ld_data;
    logic          ld_done;
    logic          run;
    logic [IW-1:0] ifid_instr;
    logic [W-1:0]  ifid_pc;
    logic [W-1:0]  ifid_pc1;
    logic          ifid_valid;

    int errors = 0;
    int checks = 0;

    // behavioural model
    logic [IW-1:0] m_mem [DEPTH];
    bit            m_running;
    logic [IW-1:0] m_instr;
    int            m_pc;
    int            m_pc1;
    bit            m_valid;

    typedef struct {
        bit            clr;
        int            pc;
        bit            stall;
        bit            flush;
        bit            ld_en;
        int            ld_addr;
        logic [IW-1:0] ld_data;
        bit            ld_done;
        bit            e_run;
        bit            e_valid;
        logic [IW-1:0] e_instr;
        int            e_pc;
        int            e_pc1;
    } vec_t;

    vec_t vecs[$];

    instr_fetch #(.W(W), .IW(IW)) dut (
        .clk        (clk),
        .clr        (clr),
        .pc         (pc),
        .stall      (stall),
        .flush      (flush),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_done    (ld_done),
        .run        (run),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .ifid_pc1   (ifid_pc1),
        .ifid_valid (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (clr) begin
            m_running = 0;
            m_instr = '0; m_pc = 0; m_pc1 = 0; m_valid = 0;
        end else if (!m_running) begin
            if (ld_en) m_mem[ld_addr] = ld_data;
            if (ld_done) m_running = 1;
        end else if (flush) begin
            m_instr = '0; m_pc = 0; m_pc1 = 0; m_valid = 0;
        end else if (!stall) begin
            m_instr = m_mem[pc];
            m_pc    = pc;
            m_pc1   = (pc + 1) % DEPTH;
            m_valid = 1;
        end
    endtask

    task automatic drive(input bit c, input int p, input bit s, input bit f,
                         input bit le, input int la, input logic [IW-1:0] ld,
                         input bit dn);
        clr = c; pc = W'(p); stall = s; flush = f;
        ld_en = le; ld_addr = W'(la); ld_data = ld; ld_done = dn;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".run"},   64'(run),        64'(m_running));
        chk({tag, ".valid"}, 64'(ifid_valid), 64'(m_valid));
        chk({tag, ".instr"}, 64'(ifid_instr), 64'(m_instr));
        chk({tag, ".pc"},    64'(ifid_pc),    64'(m_pc));
        chk({tag, ".pc1"},   64'(ifid_pc1),   64'(m_pc1));
    endtask

    task automatic add(input bit c, input int p, input bit s, input bit f,
                       input bit le, input int la, input logic [IW-1:0] ld, input bit dn,
                       input bit er, input bit ev, input logic [IW-1:0] ei,
                       input int ep, input int ep1);
        vec_t v;
        v.clr = c; v.pc = p; v.stall = s; v.flush = f;
        v.ld_en = le; v.ld_addr = la; v.ld_data = ld; v.ld_done = dn;
        v.e_run = er; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_pc1 = ep1;
        vecs.push_back(v);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, '0, 0);
        chk("reset.run",   64'(run),        64'd0);
        chk("reset.valid", 64'(ifid_valid), 64'd0);
        chk("reset.instr", 64'(ifid_instr), 64'd0);
        chk("reset.pc",    64'(ifid_pc),    64'd0);
        chk("reset.pc1",   64'(ifid_pc1),   64'd0);

        // fill whole memory so every later fetch has a known value
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, 1, a, IW'($urandom), 0);
        end
        chk("preload.run", 64'(run), 64'd0);

        //  clr pc st fl le addr data       done | run v instr       pc pc1
        add(0, 0, 0, 0, 1, 0,  32'h11,     0,     0, 0, 32'h0,     0, 0);
        add(0, 0, 0, 0, 1, 1,  32'h22,     0,     0, 0, 32'h0,     0, 0);
        add(0, 0, 0, 0, 1, 2,  32'h33,     0,     0, 0, 32'h0,     0, 0);
        add(0, 0, 0, 0, 1, 3,  32'h44,     0,     0, 0, 32'h0,     0, 0);
        add(0, 0, 0, 0, 1, 63, 32'hDEAD,   0,     0, 0, 32'h0,     0, 0);
        add(0, 0, 0, 0, 0, 0,  32'h0,      1,     1, 0, 32'h0,     0, 0);
        add(0, 0, 0, 0, 0, 0,  32'h0,      0,     1, 1, 32'h11,    0, 1);
        add(0, 1, 0, 0, 0, 0,  32'h0,      0,     1, 1, 32'h22,    1, 2);
        add(0, 2, 0, 0, 0, 0,  32'h0,      0,     1, 1, 32'h33,    2, 3);
        add(0, 3, 0, 0, 0, 0,  32'h0,      0,     1, 1, 32'h44,    3, 4);
        add(0, 2, 0, 0, 0, 0,  32'h0,      0,     1, 1, 32'h33,    2, 3);
        add(0, 2, 1, 0, 0, 0,  32'h0,      0,     1, 1, 32'h33,    2, 3);
        add(0, 2, 1, 0, 0, 0,  32'h0,      0,     1, 1, 32'h33,    2, 3);
        add(0, 2, 1, 1, 0, 0,  32'h0,      0,     1, 0, 32'h0,     0, 0);
        add(0, 0, 1, 0, 0, 0,  32'h0,      0,     1, 0, 32'h0,     0, 0);
        add(0, 3, 0, 0, 0, 0,  32'h0,      0,     1, 1, 32'h44,    3, 4);
        add(0, 1, 0, 1, 0, 0,  32'h0,      0,     1, 0, 32'h0,     0, 0);
        add(0, 63,0, 0, 0, 0,  32'h0,      0,     1, 1, 32'hDEAD,  63, 0);
        add(0, 3, 0, 0, 1, 0,  32'hFF,     0,     1, 1, 32'h44,    3, 4);
        add(0, 0, 0, 0, 0, 0,  32'h0,      1,     1, 1, 32'h11,    0, 1);
        add(1, 2, 1, 1, 1, 0,  32'hFF,     1,     0, 0, 32'h0,     0, 0);
        add(0, 1, 0, 0, 0, 0,  32'h0,      0,     0, 0, 32'h0,     0, 0);
        add(0, 1, 0, 0, 0, 0,  32'h0,      1,     1, 0, 32'h0,     0, 0);
        add(0, 1, 0, 0, 0, 0,  32'h0,      0,     1, 1, 32'h22,    1, 2);
        add(1, 0, 0, 0, 0, 0,  32'h0,      0,     0, 0, 32'h0,     0, 0);
        add(0, 0, 0, 0, 1, 5,  32'h55,     1,     1, 0, 32'h0,     0, 0);
        add(0, 5, 0, 0, 0, 0,  32'h0,      0,     1, 1, 32'h55,    5, 6);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].pc, vecs[i].stall, vecs[i].flush,
                  vecs[i].ld_en, vecs[i].ld_addr, vecs[i].ld_data, vecs[i].ld_done);
            chk($sformatf("vec%0d.run", i),   64'(run),        64'(vecs[i].e_run));
            chk($sformatf("vec%0d.valid", i), 64'(ifid_valid), 64'(vecs[i].e_valid));
            chk($sformatf("vec%0d.instr", i), 64'(ifid_instr), 64'(vecs[i].e_instr));
            chk($sformatf("vec%0d.pc", i),    64'(ifid_pc),    64'(vecs[i].e_pc));
            chk($sformatf("vec%0d.pc1", i),   64'(ifid_pc1),   64'(vecs[i].e_pc1));
        end

        // clr wins over a simultaneous load and done in LOAD
        drive(1, 0, 0, 0, 0, 0, '0, 0);
        drive(1, 0, 0, 0, 1, 5, 32'h99, 1);
        chk("clrprio.run", 64'(run), 64'd0);
        drive(0, 0, 0, 0, 0, 0, '0, 1);
        chk("clrprio.enter", 64'(run), 64'd1);
        drive(0, 5, 0, 0, 0, 0, '0, 0);
        chk("clrprio.instr", 64'(ifid_instr), 64'h55);

        // flush with a clr-free RUN, then immediate refetch
        drive(0, 4, 1, 1, 0, 0, '0, 0);
        chk("flush.valid", 64'(ifid_valid), 64'd0);
        drive(0, 63, 0, 0, 0, 0, '0, 0);
        chk("wrap.pc1", 64'(ifid_pc1), 64'd0);
        chk("wrap.instr", 64'(ifid_instr), 64'hDEAD);

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 29) == 0), int'($urandom_range(0, DEPTH - 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, DEPTH - 1)),
                  IW'($urandom), ($urandom_range(0, 7) == 0));
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter W, default 6: instruction address width, the same as the program counter width.
REQ-002 Parameter IW, default 32: instruction width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset; synchronous, active-high.
REQ-005 pc  input  W  current program counter value from the PC stage.
REQ-006 stall  input  1  hold the IF/ID register.
REQ-007 flush  input  1  replace the IF/ID contents with a bubble.
REQ-008 ld_en  input  1  program-load write strobe.
REQ-009 ld_addr  input  W  program-load word address.
REQ-010 ld_data  input  IW  program-load instruction word.
REQ-011 ld_done  input  1  program load complete.
REQ-012 run  output  1  high in RUN state; the PC stage is held in clr while low.
REQ-013 ifid_instr  output  IW  fetched instruction.
REQ-014 ifid_pc  output  W  address of ifid_instr.
REQ-015 ifid_pc1  output  W  ifid_pc+1 modulo 2^W, the sequential successor used for branch-target computation.
REQ-016 ifid_valid  output  1  IF/ID holds a real instruction.

Function
REQ-017 The block SHALL contain a 2^W x IW instruction memory with a synchronous write port and a combinational read port indexed by pc.
REQ-018 The block SHALL implement a two-state FSM, LOAD and RUN, with LOAD as the reset state.
REQ-019 In LOAD, ld_en=1 SHALL write ld_data to mem[ld_addr] at the clock edge.
- While in LOAD, ifid_valid=0 and run=0.
REQ-020 In LOAD, ld_done=1 SHALL move the FSM to RUN at the next edge.
- If ld_en is also high in that cycle, the write SHALL still occur.
REQ-021 In RUN, ld_en and ld_done SHALL be ignored; memory is read-only.
- RUN SHALL persist until clr.
REQ-022 In RUN, with flush=0 and stall=0, each edge SHALL capture mem[pc], pc, (pc+1) mod 2^W, and valid=1 into the IF/ID register.
- Latency from pc to the IF/ID outputs: one cycle.
REQ-023 In RUN, flush=1 SHALL load ifid_instr=NOP (all zeros), ifid_pc=0, ifid_pc1=0, ifid_valid=0.
- flush SHALL override stall.
REQ-024 In RUN, stall=1 with flush=0 SHALL hold all IF/ID outputs unchanged.
REQ-025 ifid_pc1 SHALL wrap: pc=2^W-1 gives ifid_pc1=0.
REQ-026 The first fetch after entering RUN SHALL occur at the first RUN-state edge, with run high during that cycle.

Reset
REQ-027 clr=1 at an edge SHALL set:
- FSM=LOAD, run=0;
- ifid_instr=0, ifid_pc=0, ifid_pc1=0, ifid_valid=0.
REQ-028 clr SHALL NOT clear memory contents.
- A reset mid-RUN SHALL return to LOAD with the program retained.
- Asserting ld_done alone SHALL then resume execution.
REQ-029 clr SHALL take priority over ld_en, ld_done, stall and flush.

Structure
REQ-030 Package mips_pkg SHALL hold:
- the IW default;
- the NOP constant;
- the FSM state encoding.
REQ-031 The memory SHALL be a separate sub-module instr_mem, with parameters W and IW, one synchronous write port and one combinational read port.
- The FSM and the IF/ID register SHALL live in instr_fetch.

Verification
REQ-032 Load and fetch: load mem[0..3]=0x11,0x22,0x33,0x44, pulse ld_done, drive pc 0,1,2,3 -> ifid_instr 0x11,0x22,0x33,0x44 one cycle later each, ifid_valid=1, ifid_pc1=1,2,3,4.
REQ-033 Stall/flush: stall for 2 cycles while pc=2, then flush+stall together -> ifid_instr holds 0x33 for 2 cycles, then NOP with ifid_valid=0.
REQ-034 Wrap: load mem[63]=0xDEAD, pc=63 -> ifid_instr=0xDEAD, ifid_pc=63, ifid_pc1=0.
REQ-035 Loads ignored in RUN: in RUN, ld_en=1 with ld_addr=0 and ld_data=0xFF -> a later fetch at pc=0 still returns 0x11.
REQ-036 Reset mid-RUN: clr in RUN -> all outputs 0 and run=0 next cycle; after ld_done and pc=1 -> ifid_instr=0x22.
REQ-037 Simultaneous load and done: ld_en and ld_done in the same cycle with ld_addr=5 and ld_data=0x55 -> FSM enters RUN, and pc=5 fetches 0x55.
